rfblackwidow_pit_irq: RTL and testbench

Timer interrupt scheduler for the four-channel programmable interval timer. It captures rising edges on the four timer outputs as pending events and masks them. It arbitrates among the pending events with fixed or round-robin priority, and presents one request at a time to the CPU with a vector/acknowledge/end-of-interrupt handshake. It sits between the timer's `out0..out3` pins and the CPU interrupt input, and is configured over the same 32-bit slave bus as the timer.

---
 rtl/rfblackwidow_pit_irq_if.sv | 24 ++
 rtl/rfblackwidow_pit_irq.sv | 257 +++++++++++++++++++++++++
 tb/tb_rfblackwidow_pit_irq.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rfblackwidow_pit_irq_if.sv
// Slave bus bundle shared by the interval timer and its interrupt scheduler.
// The master drives the select, strobe, address and write data. The slave
// returns the read data and the acknowledge.
interface rfblackwidow_pit_irq_if;
    logic        cs_i;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [3:0]  adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport master (
        output cs_i, cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  cs_i, cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        output dat_o, ack_o
    );
endinterface

// File: rtl/rfblackwidow_pit_irq.sv
// Timer interrupt scheduler for the four-channel interval timer.
// A rising edge on a timer output, or a high level in level mode, becomes a
// pending event. The pending events are masked and arbitrated with fixed or
// round-robin priority. The winner is presented to the CPU as one request at a
// time, and the CPU answers with an acknowledge pulse and then an EOI write.
module rfblackwidow_pit_irq #(
    parameter logic [7:0] VECBASE  = 8'h20,
    parameter logic       RR_RESET = 1'b0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    rfblackwidow_pit_irq_if.slave       bus,
    input  logic [3:0]                  tmr_i,
    input  logic                        iack_i,
    output logic                        irq_o,
    output logic [7:0]                  cause_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_REQ  = 2'd2,
        ST_SVC  = 2'd3
    } state_t;

    // Register map, selected by adr_i[3:2]
    localparam logic [1:0] A_PEND  = 2'd0;
    localparam logic [1:0] A_MASK  = 2'd1;
    localparam logic [1:0] A_INSVC = 2'd2;
    localparam logic [1:0] A_CTRL  = 2'd3;

    // One-hot decode of a channel number
    function automatic logic [3:0] onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Choose a winner among the requests. Fixed priority scans from ch0.
    // Round-robin scans from the channel after the most recently acknowledged one.
    function automatic logic [1:0] pick_winner(input logic [3:0] req,
                                               input logic       rr,
                                               input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = rr ? (last + 2'(k) + 2'd1) : 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end else begin
                win   = win;
                found = found;
            end
        end
        return win;
    endfunction

    // Bus decode
    logic        cs_s;
    logic        wr_s;
    logic [1:0]  adr_s;
    logic        rdy_r;
    logic [31:0] dat_r;
    logic [31:0] rd_mux_s;

    // Event and status registers
    logic [3:0]  tmr_q_r;
    logic [3:0]  pend_r;
    logic [3:0]  mask_r;
    logic [3:0]  insvc_r;
    logic [2:0]  ctrl_r;
    logic [3:0]  pend_nxt_s;
    logic [3:0]  insvc_nxt_s;
    logic [3:0]  set_s;
    logic [3:0]  w1c_s;
    logic [3:0]  eoi_s;
    logic [3:0]  iack_clr_s;
    logic [3:0]  req_s;
    logic [1:0]  win_s;

    // Scheduler state
    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  ch_r;
    logic [1:0]  last_r;
    logic        irq_r;
    logic [7:0]  cause_r;
    logic        grant_s;
    logic        take_s;
    logic        drop_s;

    // Bus bits that carry no function in this block
    logic unused_s;
    assign unused_s = ^{bus.dat_i[31:4], bus.adr_i[1:0], bus.sel_i[3:1]};

    assign cs_s  = bus.cs_i & bus.cyc_i & bus.stb_i;
    assign wr_s  = cs_s & bus.we_i & bus.sel_i[0];
    assign adr_s = bus.adr_i[3:2];

    // A write completes in the same cycle. A read waits one cycle for the registered data.
    assign bus.ack_o = cs_s ? (bus.we_i ? 1'b1 : rdy_r) : 1'b0;
    assign bus.dat_o = dat_r;

    assign irq_o   = irq_r;
    assign cause_o = cause_r;

    // Decode the write-one-to-clear strobes for PEND and INSVC (INSVC is the EOI).
    always_comb begin
        w1c_s = 4'b0000;
        eoi_s = 4'b0000;
        if (wr_s && (adr_s == A_PEND)) begin
            w1c_s = bus.dat_i[3:0];
        end else begin
            w1c_s = 4'b0000;
        end
        if (wr_s && (adr_s == A_INSVC)) begin
            eoi_s = bus.dat_i[3:0];
        end else begin
            eoi_s = 4'b0000;
        end
    end

    // Read data multiplexer
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (adr_s)
            A_PEND:  rd_mux_s = {28'h000_0000, pend_r};
            A_MASK:  rd_mux_s = {28'h000_0000, mask_r};
            A_INSVC: rd_mux_s = {28'h000_0000, insvc_r};
            A_CTRL:  rd_mux_s = {29'h0000_0000, ctrl_r};
            default: rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Work out the next PEND and INSVC values. A new event wins over every clear, so it is never lost.
    always_comb begin
        set_s       = (tmr_i & ~tmr_q_r) | (ctrl_r[2] ? tmr_i : 4'b0000);
        iack_clr_s  = take_s ? onehot(ch_r) : 4'b0000;
        pend_nxt_s  = set_s | (pend_r & ~iack_clr_s & ~w1c_s);
        insvc_nxt_s = iack_clr_s | (insvc_r & ~eoi_s);
    end

    assign req_s = pend_r & mask_r;
    assign win_s = pick_winner(req_s, ctrl_r[1], last_r);

    // Bus read pipeline: ready flag and registered read data, which is zero while not selected
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdy_r <= 1'b0;
            dat_r <= 32'h0000_0000;
        end else begin
            rdy_r <= cs_s;
            dat_r <= cs_s ? rd_mux_s : 32'h0000_0000;
        end
    end

    // Configuration, edge detector and event status registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmr_q_r <= 4'b0000;
            pend_r  <= 4'b0000;
            insvc_r <= 4'b0000;
            mask_r  <= 4'b0000;
            ctrl_r  <= {1'b0, RR_RESET, 1'b0};
        end else begin
            tmr_q_r <= tmr_i;
            pend_r  <= pend_nxt_s;
            insvc_r <= insvc_nxt_s;
            if (wr_s && (adr_s == A_MASK)) begin
                mask_r <= bus.dat_i[3:0];
            end
            if (wr_s && (adr_s == A_CTRL)) begin
                ctrl_r <= bus.dat_i[2:0];
            end
        end
    end

    // Scheduler state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Scheduler next state and per-cycle actions: grant, acknowledge and withdraw
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        take_s      = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ctrl_r[0] && (|req_s)) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARB: begin
                // The request may already be gone: a W1C write or a mask write can land between the two states.
                if (|req_s) begin
                    grant_s     = 1'b1;
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (iack_i) begin
                    take_s      = 1'b1;
                    state_nxt_s = ST_SVC;
                end else if (!ctrl_r[0] || !pend_r[ch_r] || !mask_r[ch_r]) begin
                    drop_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_SVC: begin
                if (eoi_s[ch_r]) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SVC;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Request outputs, granted channel and round-robin history. cause_o keeps its last value while idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_r   <= 1'b0;
            cause_r <= VECBASE;
            ch_r    <= 2'd0;
            last_r  <= 2'd3;
        end else begin
            if (grant_s) begin
                irq_r   <= 1'b1;
                cause_r <= VECBASE + {6'b00_0000, win_s};
                ch_r    <= win_s;
            end else if (take_s || drop_s) begin
                irq_r   <= 1'b0;
            end
            if (take_s) begin
                last_r <= ch_r;
            end
        end
    end

endmodule

// File: tb/tb_rfblackwidow_pit_irq.sv
// Self-checking bench for the timer interrupt scheduler. A behavioural model
// predicts irq_o and cause_o every cycle and the register contents at every
// read. Literal expectations pin the model on the directed scenarios.
module tb_rfblackwidow_pit_irq;

    localparam int PH_IDLE = 0;
    localparam int PH_ARB  = 1;
    localparam int PH_REQ  = 2;
    localparam int PH_SVC  = 3;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [3:0] tmr_i = 4'h0;
    logic       iack_i = 1'b0;
    logic       irq_o;
    logic [7:0] cause_o;

    int n_cmp = 0;
    int n_bad = 0;

    rfblackwidow_pit_irq_if bus ();

    rfblackwidow_pit_irq #(.VECBASE(8'h20), .RR_RESET(1'b0)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .bus     (bus.slave),
        .tmr_i   (tmr_i),
        .iack_i  (iack_i),
        .irq_o   (irq_o),
        .cause_o (cause_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- behavioural model ----------------
    logic [3:0] m_pend, m_mask, m_insvc, m_tq;
    logic [2:0] m_ctrl;
    int         m_phase, m_ch, m_last;
    logic       m_irq;
    logic [7:0] m_cause;

    // Return the granted channel. Fixed priority: lowest index. Round-robin: first one after the last acknowledged channel.
    function automatic int pick(input logic [3:0] req, input logic rr, input int last);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = rr ? (last + k) % 4 : k - 1;
            if (req[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic logic [31:0] model_reg(input logic [1:0] a);
        case (a)
            2'd0:    return {28'h0, m_pend};
            2'd1:    return {28'h0, m_mask};
            2'd2:    return {28'h0, m_insvc};
            default: return {29'h0, m_ctrl};
        endcase
    endfunction

    // Advance the model one clock. Priority, lowest first: W1C write, acknowledge clear, new event.
    always @(posedge clk_i or posedge rst_i) begin : model
        logic        wr;
        logic [1:0]  a;
        logic [31:0] d;
        logic [3:0]  setv, pm, np, ni;
        int          w;
        if (rst_i) begin
            m_pend <= 4'h0; m_mask <= 4'h0; m_insvc <= 4'h0; m_tq <= 4'h0;
            m_ctrl <= 3'b000; m_phase <= PH_IDLE; m_ch <= 0; m_last <= 3;
            m_irq <= 1'b0; m_cause <= 8'h20;
        end else begin
            wr   = bus.cs_i & bus.cyc_i & bus.stb_i & bus.we_i & bus.sel_i[0];
            a    = bus.adr_i[3:2];
            d    = bus.dat_i;
            setv = (tmr_i & ~m_tq) | (m_ctrl[2] ? tmr_i : 4'h0);
            pm   = m_pend & m_mask;
            np   = m_pend;
            ni   = m_insvc;
            if (wr && a == 2'd0) np = np & ~d[3:0];
            if (wr && a == 2'd2) ni = ni & ~d[3:0];
            if (m_phase == PH_REQ && iack_i) begin
                np[m_ch] = 1'b0;
                ni[m_ch] = 1'b1;
            end
            np = np | setv;
            m_pend  <= np;
            m_insvc <= ni;
            m_tq    <= tmr_i;
            if (wr && a == 2'd1) m_mask <= d[3:0];
            if (wr && a == 2'd3) m_ctrl <= d[2:0];
            case (m_phase)
                PH_IDLE: if (m_ctrl[0] && pm != 4'h0) m_phase <= PH_ARB;
                PH_ARB: begin
                    if (pm == 4'h0) m_phase <= PH_IDLE;
                    else begin
                        w = pick(pm, m_ctrl[1], m_last);
                        m_ch    <= w;
                        m_irq   <= 1'b1;
                        m_cause <= 8'h20 + 8'(w);
                        m_phase <= PH_REQ;
                    end
                end
                PH_REQ: begin
                    if (iack_i) begin
                        m_last <= m_ch; m_irq <= 1'b0; m_phase <= PH_SVC;
                    end else if (!m_ctrl[0] || !m_pend[m_ch] || !m_mask[m_ch]) begin
                        m_irq <= 1'b0; m_phase <= PH_IDLE;
                    end
                end
                PH_SVC: if (wr && a == 2'd2 && d[m_ch]) m_phase <= PH_IDLE;
                default: m_phase <= PH_IDLE;
            endcase
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bus_idle();
        bus.cs_i = 1'b0; bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        bus.sel_i = 4'h0; bus.adr_i = 4'h0; bus.dat_i = 32'h0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk_i); #1;
        bus.cs_i = 1'b1; bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
        bus.sel_i = 4'hF; bus.adr_i = {a, 2'b00}; bus.dat_i = d;
        @(negedge clk_i);
        chk("wr_ack", {31'h0, bus.ack_o}, 32'h1);
        @(posedge clk_i); #1;
        bus_idle();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d, output logic [31:0] m);
        int n;
        @(posedge clk_i); #1;
        bus.cs_i = 1'b1; bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
        bus.sel_i = 4'hF; bus.adr_i = {a, 2'b00};
        @(negedge clk_i);
        m = model_reg(a);
        n = 0;
        while (!bus.ack_o && n < 8) begin
            @(negedge clk_i);
            n++;
        end
        if (!bus.ack_o) begin
            n_cmp++; n_bad++;
            $display("FAIL rd_ack: no acknowledge within 8 cycles");
        end
        d = bus.dat_o;
        @(posedge clk_i); #1;
        bus_idle();
    endtask

    // Read a register and compare it with a literal value and with the model
    task automatic rd_lit(input logic [1:0] a, input string name, input logic [31:0] exp);
        logic [31:0] d, m;
        bus_read(a, d, m);
        chk(name, d, exp);
        chk({name, "_model"}, d, m);
    endtask

    task automatic rd_mod(input logic [1:0] a, input string name);
        logic [31:0] d, m;
        bus_read(a, d, m);
        chk(name, d, m);
    endtask

    task automatic pulse(input logic [3:0] v);
        @(posedge clk_i); #1; tmr_i = v;
        @(posedge clk_i); #1; tmr_i = 4'h0;
    endtask

    task automatic iack_pulse();
        @(posedge clk_i); #1; iack_i = 1'b1;
        @(posedge clk_i); #1; iack_i = 1'b0;
        @(negedge clk_i);
        chk("irq_after_iack", {31'h0, irq_o}, 32'h0);
    endtask

    task automatic wait_irq(input int budget);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!irq_o && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        if (!irq_o) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_irq: irq_o not raised within %0d cycles", budget);
        end
    endtask

    // ---------------- stimulus and checking ----------------
    logic [7:0] rr_exp [5] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h20};

    initial begin
        bus_idle();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        fork
            begin : compare
                forever begin
                    @(negedge clk_i);
                    if (!rst_i) begin
                        chk("irq_o", {31'h0, irq_o}, {31'h0, m_irq});
                        chk("cause_o", {24'h0, cause_o}, {24'h0, m_cause});
                    end
                end
            end
            begin : watchdog
                repeat (40000) @(posedge clk_i);
                n_cmp++; n_bad++;
                $display("FAIL watchdog: run exceeded cycle budget");
            end
            begin : main
                // Reset state
                @(negedge clk_i);
                chk("rst_irq", {31'h0, irq_o}, 32'h0);
                chk("rst_cause", {24'h0, cause_o}, 32'h20);
                rd_lit(2'd0, "rst_pend", 32'h0);
                rd_lit(2'd1, "rst_mask", 32'h0);
                rd_lit(2'd2, "rst_insvc", 32'h0);
                rd_lit(2'd3, "rst_ctrl", 32'h0);

                // Basic handshake on ch2 with latency pinned
                bus_write(2'd1, 32'hF);
                bus_write(2'd3, 32'h1);
                pulse(4'h4);
                @(posedge clk_i); @(negedge clk_i);
                chk("lat_t2_irq", {31'h0, irq_o}, 32'h0);
                @(posedge clk_i); @(negedge clk_i);
                chk("lat_t3_irq", {31'h0, irq_o}, 32'h1);
                chk("lat_t3_cause", {24'h0, cause_o}, 32'h22);
                iack_pulse();
                rd_lit(2'd0, "ack_pend", 32'h0);
                rd_lit(2'd2, "ack_insvc", 32'h4);
                bus_write(2'd2, 32'h4);
                rd_lit(2'd2, "eoi_insvc", 32'h0);

                // Fixed priority: ch1 before ch3
                pulse(4'hA);
                wait_irq(20);
                chk("fix_first", {24'h0, cause_o}, 32'h21);
                iack_pulse();
                bus_write(2'd2, 32'h2);
                wait_irq(20);
                chk("fix_second", {24'h0, cause_o}, 32'h23);
                iack_pulse();
                bus_write(2'd2, 32'h8);

                // Round-robin with all channels kept pending
                bus_write(2'd3, 32'h3);
                for (int i = 0; i < 5; i++) begin
                    logic [31:0] e;
                    pulse(4'hF);
                    wait_irq(20);
                    chk("rr_vec", {24'h0, cause_o}, {24'h0, rr_exp[i]});
                    iack_pulse();
                    e = 32'h1 << (i % 4);
                    bus_write(2'd2, e);
                end
                bus_write(2'd3, 32'h0);
                bus_write(2'd0, 32'hF);
                rd_lit(2'd0, "rr_clean", 32'h0);

                // Withdrawal by masking ch0 while it is requested
                bus_write(2'd3, 32'h1);
                pulse(4'h1);
                wait_irq(20);
                chk("wd_cause", {24'h0, cause_o}, 32'h20);
                bus_write(2'd1, 32'hE);
                repeat (2) @(negedge clk_i);
                chk("wd_irq", {31'h0, irq_o}, 32'h0);
                rd_lit(2'd2, "wd_insvc", 32'h0);
                rd_lit(2'd0, "wd_pend", 32'h1);
                bus_write(2'd1, 32'hF);
                wait_irq(20);
                chk("wd_rereq", {24'h0, cause_o}, 32'h20);
                iack_pulse();
                bus_write(2'd2, 32'h1);

                // Collision of a W1C write and a new rise on ch1
                bus_write(2'd3, 32'h0);
                pulse(4'h2);
                @(posedge clk_i); #1;
                bus.cs_i = 1'b1; bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
                bus.sel_i = 4'h1; bus.adr_i = 4'h0; bus.dat_i = 32'h2;
                tmr_i = 4'h2;
                @(posedge clk_i); #1;
                bus_idle();
                tmr_i = 4'h0;
                rd_lit(2'd0, "coll_pend", 32'h2);
                bus_write(2'd0, 32'h2);
                rd_lit(2'd0, "coll_clr", 32'h0);

                // Level mode: a held input cannot be cleared
                bus_write(2'd3, 32'h4);
                @(posedge clk_i); #1; tmr_i = 4'h1;
                bus_write(2'd0, 32'h1);
                rd_lit(2'd0, "lvl_hold", 32'h1);
                @(posedge clk_i); #1; tmr_i = 4'h0;
                bus_write(2'd0, 32'h1);
                rd_lit(2'd0, "lvl_clr", 32'h0);

                // Randomized traffic checked by the model
                bus_write(2'd1, 32'hF);
                bus_write(2'd3, 32'h1);
                for (int c = 0; c < 800; c++) begin
                    @(posedge clk_i); #1;
                    tmr_i  = ($urandom % 4 == 0) ? 4'($urandom) : 4'h0;
                    iack_i = irq_o ? ($urandom % 3 == 0) : ($urandom % 20 == 0);
                    if ($urandom % 6 == 0) begin
                        bus.cs_i  = ($urandom % 8 != 0);
                        bus.cyc_i = ($urandom % 8 != 0);
                        bus.stb_i = ($urandom % 8 != 0);
                        bus.we_i  = 1'b1;
                        bus.sel_i = 4'($urandom);
                        bus.adr_i = 4'($urandom);
                        bus.dat_i = $urandom;
                        if (bus.adr_i[3:2] == 2'd3) bus.dat_i[0] = ($urandom % 4 != 0);
                    end else begin
                        bus_idle();
                    end
                end
                @(posedge clk_i); #1;
                bus_idle(); tmr_i = 4'h0; iack_i = 1'b0;
                rd_mod(2'd0, "rnd_pend");
                rd_mod(2'd1, "rnd_mask");
                rd_mod(2'd2, "rnd_insvc");
                rd_mod(2'd3, "rnd_ctrl");

                // Asynchronous reset in the middle of a request
                bus_write(2'd3, 32'h0);
                bus_write(2'd0, 32'hF);
                bus_write(2'd2, 32'hF);
                bus_write(2'd1, 32'hF);
                bus_write(2'd3, 32'h1);
                pulse(4'h1);
                wait_irq(20);
                #1 rst_i = 1'b1;
                #1;
                chk("arst_irq", {31'h0, irq_o}, 32'h0);
                chk("arst_cause", {24'h0, cause_o}, 32'h20);
                repeat (2) @(posedge clk_i);
                #1 rst_i = 1'b0;
                rd_lit(2'd0, "arst_pend", 32'h0);
                rd_lit(2'd1, "arst_mask", 32'h0);
                rd_lit(2'd2, "arst_insvc", 32'h0);
                rd_lit(2'd3, "arst_ctrl", 32'h0);
                pulse(4'hF);
                repeat (10) @(negedge clk_i);
                chk("arst_noreq", {31'h0, irq_o}, 32'h0);
            end
        join_any
        disable fork;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
